// File: rtl/alu_cmd_ctrl_pkg.sv
// rtl/alu_cmd_ctrl_pkg.sv - shared types and constants for the ALU command front end
//
// Package alu_cmd_pkg: controller state encoding, opcode tag, status byte
// constants, ALU unit-select codes and a constant helper for sizing counters.

package alu_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_WAIT_RES,
    ST_SEND_ST,
    ST_SEND_RES
  } state_t;

  localparam logic [3:0] CMD_TAG      = 4'hA;
  localparam logic [3:0] STATUS_OK_HI = 4'h5;
  localparam logic [7:0] STATUS_ERR   = 8'hEE;

  // ALU_FUN[3:2] selects which ALU unit owns the result
  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_CMP   = 2'b10;
  localparam logic [1:0] SEL_SHIFT = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// rtl/alu_cmd_ctrl_if.sv - byte stream and ALU side bundle of the command front end
//
// master: the controller (consumes RX bytes and ALU results, drives TX,
//         ALU operands/function, CMD_ERR and BUSY).
// slave : the surroundings (byte receiver, byte transmitter, ALU).

interface alu_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 16
);

  logic [7:0]            RX_P_DATA;
  logic                  RX_D_VLD;
  logic [7:0]            TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_READY;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic [3:0]            ALU_FUN;
  logic [DATA_WIDTH-1:0] ARITH_OUT;
  logic [DATA_WIDTH-1:0] LOGIC_OUT;
  logic [DATA_WIDTH-1:0] CMP_OUT;
  logic [DATA_WIDTH-1:0] SHIFT_OUT;
  logic                  ARITH_FLAG;
  logic                  LOGIC_FLAG;
  logic                  CMP_FLAG;
  logic                  SHIFT_FLAG;
  logic                  CARRY_OUT;
  logic                  CMD_ERR;
  logic                  BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, TX_READY,
    input  ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT,
    input  ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, CARRY_OUT,
    output TX_P_DATA, TX_D_VLD, ALU_A, ALU_B, ALU_FUN, CMD_ERR, BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, TX_READY,
    output ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT,
    output ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, CARRY_OUT,
    input  TX_P_DATA, TX_D_VLD, ALU_A, ALU_B, ALU_FUN, CMD_ERR, BUSY
  );

endinterface

// File: rtl/alu_cmd_ctrl_result_sel.sv
// rtl/alu_cmd_ctrl_result_sel.sv - picks the flagged ALU unit's result
//
// Module alu_result_sel (combinational).
// sel           : ALU_FUN[3:2] unit select
// *_out/*_flag  : per-unit result and valid flag
// carry_out     : arithmetic carry
// flag/result   : selected unit's flag and result
// carry         : carry qualified to the arithmetic unit (0 for other units)

module alu_result_sel
  import alu_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] arith_out,
  input  logic [DATA_WIDTH-1:0] logic_out,
  input  logic [DATA_WIDTH-1:0] cmp_out,
  input  logic [DATA_WIDTH-1:0] shift_out,
  input  logic                  arith_flag,
  input  logic                  logic_flag,
  input  logic                  cmp_flag,
  input  logic                  shift_flag,
  input  logic                  carry_out,
  output logic                  flag,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry
);

  always_comb begin
    flag   = 1'b0;
    result = '0;
    carry  = 1'b0;
    case (sel)
      SEL_ARITH: begin
        flag   = arith_flag;
        result = arith_out;
        carry  = carry_out;
      end
      SEL_LOGIC: begin
        flag   = logic_flag;
        result = logic_out;
      end
      SEL_CMP: begin
        flag   = cmp_flag;
        result = cmp_out;
      end
      SEL_SHIFT: begin
        flag   = shift_flag;
        result = shift_out;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - byte-stream command front end for the ALU
//
// Assembles {opcode, A, B} frames (operands LSB first) from RX bytes, drives
// ALU_FUN/ALU_A/ALU_B, samples the flagged unit ALU_LAT+1 cycles after B is
// complete and streams a status byte plus NB result bytes on TX.
// CLK  : clock, rising edge
// RST  : asynchronous active-low reset
// bus  : alu_cmd_ctrl_if master (RX/TX bytes, ALU operands/results, CMD_ERR, BUSY)

module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ALU_LAT    = 1,
  parameter int TO_CYCLES  = 255
) (
  input  logic           CLK,
  input  logic           RST,
  alu_cmd_ctrl_if.master bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(max_int(TO_CYCLES, ALU_LAT + 1) + 1);
  localparam int IW = $clog2(NB) + 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYCLES - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic                  err_q, err_nx;
  logic                  load_fun, load_a, load_b, capture;

  logic [3:0]            alu_fun;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, result;
  logic [7:0]            status;
  logic                  status_ok;

  logic                  sel_flag, sel_carry;
  logic [DATA_WIDTH-1:0] sel_result;

  // Byte lane addressed by idx, shared by operand loading and result sending
  logic [DATA_WIDTH-1:0] byte_mask, rx_shifted, res_shifted;

  assign byte_mask   = DATA_WIDTH'(8'hFF) << {idx, 3'b000};
  assign rx_shifted  = DATA_WIDTH'(bus.RX_P_DATA) << {idx, 3'b000};
  assign res_shifted = result >> {idx, 3'b000};
  assign status_ok   = (status[7:4] == STATUS_OK_HI);

  alu_result_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_result_sel (
    .sel       (alu_fun[3:2]),
    .arith_out (bus.ARITH_OUT),
    .logic_out (bus.LOGIC_OUT),
    .cmp_out   (bus.CMP_OUT),
    .shift_out (bus.SHIFT_OUT),
    .arith_flag(bus.ARITH_FLAG),
    .logic_flag(bus.LOGIC_FLAG),
    .cmp_flag  (bus.CMP_FLAG),
    .shift_flag(bus.SHIFT_FLAG),
    .carry_out (bus.CARRY_OUT),
    .flag      (sel_flag),
    .result    (sel_result),
    .carry     (sel_carry)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      err_q <= err_nx;
    end
  end

  // cnt doubles as inter-byte timeout (GET_A/GET_B) and ALU latency timer
  // (WAIT_RES); it is cleared on every state change and accepted byte.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    err_nx   = 1'b0;
    load_fun = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA[7:4] == CMD_TAG) begin
            load_fun = 1'b1;
            state_nx = ST_GET_A;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_GET_A, ST_GET_B: begin
        // A byte in the timeout cycle takes priority over the timeout
        if (bus.RX_D_VLD) begin
          cnt_nx = '0;
          load_a = (state == ST_GET_A);
          load_b = (state == ST_GET_B);
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = (state == ST_GET_A) ? ST_GET_B : ST_WAIT_RES;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else if (cnt == TO_LAST) begin
          err_nx   = 1'b1;
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_WAIT_RES: begin
        err_nx = bus.RX_D_VLD;
        if (cnt == LAT_LAST) begin
          capture  = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_SEND_ST;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_SEND_ST: begin
        err_nx = bus.RX_D_VLD;
        if (bus.TX_READY) begin
          idx_nx   = '0;
          state_nx = status_ok ? ST_SEND_RES : ST_IDLE;
        end
      end
      ST_SEND_RES: begin
        err_nx = bus.RX_D_VLD;
        if (bus.TX_READY) begin
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_fun <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      result  <= '0;
      status  <= '0;
    end else begin
      if (load_fun) alu_fun <= bus.RX_P_DATA[3:0];
      if (load_a)   alu_a   <= (alu_a & ~byte_mask) | rx_shifted;
      if (load_b)   alu_b   <= (alu_b & ~byte_mask) | rx_shifted;
      if (capture) begin
        status <= sel_flag ? {STATUS_OK_HI, 3'b000, sel_carry} : STATUS_ERR;
        if (sel_flag) result <= sel_result;
      end
    end
  end

  assign bus.ALU_FUN   = alu_fun;
  assign bus.ALU_A     = alu_a;
  assign bus.ALU_B     = alu_b;
  assign bus.CMD_ERR   = err_q;
  assign bus.BUSY      = (state != ST_IDLE);
  assign bus.TX_D_VLD  = (state == ST_SEND_ST) || (state == ST_SEND_RES);
  assign bus.TX_P_DATA = (state == ST_SEND_ST)  ? status :
                         (state == ST_SEND_RES) ? res_shifted[7:0] : 8'h00;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl

module tb_alu_cmd_ctrl;

  localparam int DW  = 16;
  localparam int LAT = 1;
  localparam int TO  = 255;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if #(.DATA_WIDTH(DW)) bif ();

  alu_cmd_ctrl #(
    .DATA_WIDTH(DW),
    .ALU_LAT   (LAT),
    .TO_CYCLES (TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bif)
  );

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int rdy_mode = 0;        // 0: ready high, 1: random, 2: driven by the test
  logic withhold = 1'b0;   // ALU model suppresses every flag
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: {carry, result}; carry exists only for add/sub
  function automatic logic [16:0] alu_ref(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    w = '0;
    case (fun)
      4'h0: w = {1'b0, a} + {1'b0, b};
      4'h1: w = {1'b0, a} - {1'b0, b};
      4'h2: w = {1'b0, 16'(a * b)};
      4'h3: w = {1'b0, b} - {1'b0, a};
      4'h4: w = {1'b0, a & b};
      4'h5: w = {1'b0, a | b};
      4'h6: w = {1'b0, a ^ b};
      4'h7: w = {1'b0, ~(a & b)};
      4'h8: w = (a == b) ? 17'd1 : 17'd0;
      4'h9: w = (a > b)  ? 17'd2 : 17'd0;
      4'hA: w = (a < b)  ? 17'd3 : 17'd0;
      4'hB: w = (a != b) ? 17'd4 : 17'd0;
      4'hC: w = {1'b0, a >> 1};
      4'hD: w = {1'b0, a << 1};
      4'hE: w = {1'b0, b >> 1};
      default: w = {1'b0, b << 1};
    endcase
    if (fun == 4'h2) w[16] = 1'b0;
    return w;
  endfunction

  // ALU model, one register stage; every unit computes, only the selected one flags
  logic [16:0] u_ar, u_lo, u_cm, u_sh;
  assign u_ar = alu_ref({2'b00, bif.ALU_FUN[1:0]}, bif.ALU_A, bif.ALU_B);
  assign u_lo = alu_ref({2'b01, bif.ALU_FUN[1:0]}, bif.ALU_A, bif.ALU_B);
  assign u_cm = alu_ref({2'b10, bif.ALU_FUN[1:0]}, bif.ALU_A, bif.ALU_B);
  assign u_sh = alu_ref({2'b11, bif.ALU_FUN[1:0]}, bif.ALU_A, bif.ALU_B);

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bif.ARITH_OUT <= '0; bif.LOGIC_OUT <= '0; bif.CMP_OUT <= '0; bif.SHIFT_OUT <= '0;
      bif.ARITH_FLAG <= 1'b0; bif.LOGIC_FLAG <= 1'b0; bif.CMP_FLAG <= 1'b0; bif.SHIFT_FLAG <= 1'b0;
      bif.CARRY_OUT <= 1'b0;
    end else begin
      bif.ARITH_OUT  <= u_ar[15:0];
      bif.CARRY_OUT  <= u_ar[16];
      bif.LOGIC_OUT  <= u_lo[15:0];
      bif.CMP_OUT    <= u_cm[15:0];
      bif.SHIFT_OUT  <= u_sh[15:0];
      bif.ARITH_FLAG <= !withhold && (bif.ALU_FUN[3:2] == 2'd0);
      bif.LOGIC_FLAG <= !withhold && (bif.ALU_FUN[3:2] == 2'd1);
      bif.CMP_FLAG   <= !withhold && (bif.ALU_FUN[3:2] == 2'd2);
      bif.SHIFT_FLAG <= !withhold && (bif.ALU_FUN[3:2] == 2'd3);
    end
  end

  // TX sink ready
  initial begin
    bif.TX_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (rdy_mode == 0) bif.TX_READY = 1'b1;
      else if (rdy_mode == 1) bif.TX_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // TX scoreboard, hold-stability and CMD_ERR monitor
  initial begin
    logic pv, pr, pe;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pe = 1'b0; pd = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        pv = 1'b0; pe = 1'b0;
      end else begin
        if (pv && !pr) chk("tx_hold", {23'd0, bif.TX_D_VLD, bif.TX_P_DATA}, {23'd0, 1'b1, pd});
        if (bif.TX_D_VLD && bif.TX_READY) begin
          if (exp_q.size() == 0) chk("tx_extra", exp_q.size(), 1);
          else chk("tx_byte", bif.TX_P_DATA, exp_q.pop_front());
        end
        if (bif.CMD_ERR) begin
          err_cnt++;
          chk("err_width", pe, 0);
        end
        pv = bif.TX_D_VLD; pr = bif.TX_READY; pd = bif.TX_P_DATA; pe = bif.CMD_ERR;
      end
    end
  end

  task automatic push_exp(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b, input logic wh);
    logic [16:0] r;
    r = alu_ref(fun, a, b);
    if (wh) exp_q.push_back(8'hEE);
    else begin
      exp_q.push_back({4'h5, 3'b000, r[16]});
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bif.RX_P_DATA = b;
    bif.RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    bif.RX_D_VLD  = 1'b0;
    bif.RX_P_DATA = 8'($urandom);
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b, input int gmax);
    send_byte({4'hA, fun}, $urandom_range(0, gmax));
    send_byte(a[7:0],  $urandom_range(0, gmax));
    send_byte(a[15:8], $urandom_range(0, gmax));
    send_byte(b[7:0],  $urandom_range(0, gmax));
    send_byte(b[15:8], 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bif.BUSY) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_busy", bif.BUSY, 0);
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    @(negedge CLK);
    while (!bif.TX_D_VLD && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("vld_seen", bif.TX_D_VLD, 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_txv"},  bif.TX_D_VLD, 0);
    chk({tag, "_txd"},  bif.TX_P_DATA, 0);
    chk({tag, "_busy"}, bif.BUSY, 0);
    chk({tag, "_err"},  bif.CMD_ERR, 0);
    chk({tag, "_a"},    bif.ALU_A, 0);
    chk({tag, "_b"},    bif.ALU_B, 0);
    chk({tag, "_fun"},  bif.ALU_FUN, 0);
  endtask

  initial begin
    int e0;
    logic [3:0] fun;
    logic [15:0] a, b;
    logic wh;
    bif.RX_D_VLD = 1'b0;
    bif.RX_P_DATA = 8'h00;

    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outputs("rst");
    RST = 1'b1;
    @(posedge CLK); #1;

    // ADD without carry, latency of first TX_D_VLD
    e0 = err_cnt;
    push_exp(4'h0, 16'h1234, 16'h0011, 1'b0);
    send_frame(4'h0, 16'h1234, 16'h0011, 0);
    @(negedge CLK);
    chk("t1_alu_b", bif.ALU_B, 16'h0011);
    chk("t1_vld", bif.TX_D_VLD, 0);
    @(negedge CLK);
    chk("t2_vld", bif.TX_D_VLD, 0);
    @(negedge CLK);
    chk("t3_vld", bif.TX_D_VLD, 1);
    chk("t3_alu_a", bif.ALU_A, 16'h1234);
    @(posedge CLK); #1;
    drain();

    // ADD with carry
    push_exp(4'h0, 16'hFFFF, 16'h0001, 1'b0);
    send_frame(4'h0, 16'hFFFF, 16'h0001, 2);
    drain();
    chk("add_errs", err_cnt - e0, 0);

    // Backpressure: 5 low cycles on status, 3 on second result byte
    rdy_mode = 2;
    bif.TX_READY = 1'b0;
    push_exp(4'h0, 16'hABCD, 16'h1111, 1'b0);
    send_frame(4'h0, 16'hABCD, 16'h1111, 1);
    wait_vld();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      chk("bp_st_busy", bif.BUSY, 1);
      chk("bp_st_data", bif.TX_P_DATA, 8'h50);
    end
    @(posedge CLK); #1;
    bif.TX_READY = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    bif.TX_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_r1_busy", bif.BUSY, 1);
      chk("bp_r1_data", bif.TX_P_DATA, 8'hBC);
    end
    @(posedge CLK); #1;
    bif.TX_READY = 1'b1;
    rdy_mode = 0;
    drain();

    // Bad opcode tag
    e0 = err_cnt;
    send_byte(8'h30, 0);
    @(negedge CLK);
    chk("badop_err", bif.CMD_ERR, 1);
    chk("badop_busy", bif.BUSY, 0);
    @(negedge CLK);
    chk("badop_err_end", bif.CMD_ERR, 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("badop_errs", err_cnt - e0, 1);
    chk("badop_idle", bif.BUSY, 0);

    // Flag withheld by the ALU
    withhold = 1'b1;
    push_exp(4'h5, 16'h00F0, 16'h0F00, 1'b1);
    send_frame(4'h5, 16'h00F0, 16'h0F00, 0);
    drain();
    withhold = 1'b0;

    // RX byte while sending result bytes
    rdy_mode = 2;
    bif.TX_READY = 1'b0;
    push_exp(4'h6, 16'h5A5A, 16'h0FF0, 1'b0);
    send_frame(4'h6, 16'h5A5A, 16'h0FF0, 0);
    wait_vld();
    @(posedge CLK); #1;
    bif.TX_READY = 1'b1;
    @(posedge CLK); #1;
    bif.TX_READY = 1'b0;
    e0 = err_cnt;
    send_byte(8'hA0, 0);
    @(negedge CLK);
    chk("sres_rx_err", bif.CMD_ERR, 1);
    chk("sres_busy", bif.BUSY, 1);
    @(posedge CLK); #1;
    rdy_mode = 0;
    drain();
    chk("sres_errs", err_cnt - e0, 1);

    // Frame timeout after A0,34
    e0 = err_cnt;
    send_byte(8'hA0, 0);
    send_byte(8'h34, 0);
    repeat (TO) @(negedge CLK);
    chk("to_busy_before", bif.BUSY, 1);
    chk("to_err_before", bif.CMD_ERR, 0);
    @(negedge CLK);
    chk("to_err", bif.CMD_ERR, 1);
    chk("to_idle", bif.BUSY, 0);
    @(posedge CLK); #1;
    chk("to_errs", err_cnt - e0, 1);
    push_exp(4'h4, 16'h000F, 16'h00F0, 1'b0);
    send_frame(4'h4, 16'h000F, 16'h00F0, 0);
    drain();

    // Byte arriving in the would-be timeout cycle is accepted
    e0 = err_cnt;
    push_exp(4'h1, 16'h0005, 16'h0007, 1'b0);
    send_byte(8'hA1, TO - 1);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    send_byte(8'h00, 0);
    drain();
    chk("wins_errs", err_cnt - e0, 0);

    // Randomized frames with random backpressure and withheld flags
    e0 = err_cnt;
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      fun = 4'($urandom);
      a   = 16'($urandom);
      b   = 16'($urandom);
      if (k % 8 == 0) b = a;
      wh  = ($urandom_range(0, 5) == 0);
      withhold = wh;
      push_exp(fun, a, b, wh);
      send_frame(fun, a, b, 4);
      drain();
      withhold = 1'b0;
    end
    rdy_mode = 0;
    chk("rand_errs", err_cnt - e0, 0);

    // Asynchronous reset while the status byte is pending
    rdy_mode = 2;
    bif.TX_READY = 1'b0;
    push_exp(4'h0, 16'h0101, 16'h0202, 1'b0);
    send_frame(4'h0, 16'h0101, 16'h0202, 0);
    wait_vld();
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    chk_zero_outputs("arst");
    exp_q.delete();
    bif.TX_READY = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    rdy_mode = 0;
    @(posedge CLK); #1;
    push_exp(4'hD, 16'h8421, 16'h0000, 1'b0);
    send_frame(4'hD, 16'h8421, 16'h0000, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    chk("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
